// File: rtl/ltc2600_chain_writer_pkg.sv
// Command constants, queued command record and FSM encoding shared by the
// LTC2600 daisy-chain writer and its command FIFO.
package ltc2600_chain_writer_pkg;

   localparam logic [3:0] CMD_WRITE         = 4'h0;
   localparam logic [3:0] CMD_UPDATE        = 4'h1;
   localparam logic [3:0] CMD_WRITE_UPD_ALL = 4'h2;
   localparam logic [3:0] CMD_WRITE_UPD     = 4'h3;
   localparam logic [3:0] CMD_PWR_DOWN      = 4'h4;
   localparam logic [3:0] CMD_NOP           = 4'hF;
   localparam logic [3:0] ADDR_ALL          = 4'hF;

   // Device field is sized for the largest supported chain (8 devices).
   localparam int DEV_FIELD_W = 3;
   localparam int WORD_W      = 32;

   localparam logic [WORD_W-1:0] NOP_WORD = {8'h00, CMD_NOP, 4'h0, 16'h0000};

   typedef struct packed {
      logic [DEV_FIELD_W-1:0] dev;
      logic [3:0]             command;
      logic [3:0]             address;
      logic [15:0]            data;     // already left-justified
   } dac_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_CLEAR
   } wr_state_t;

   function automatic logic [WORD_W-1:0] dac_word(input dac_cmd_t c);
      return {8'h00, c.command, c.address, c.data};
   endfunction

endpackage

// File: rtl/ltc2600_chain_writer_if.sv
// Command port of the chain writer: one (device, command, address, data)
// record per valid/ready transfer.
interface ltc2600_chain_writer_if
   import ltc2600_chain_writer_pkg::*;
#(
   parameter int DEV_W      = 1,
   parameter int DATA_WIDTH = 16
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [DEV_W-1:0]      cmd_dev;
   logic [3:0]            cmd_command;
   logic [3:0]            cmd_address;
   logic [DATA_WIDTH-1:0] cmd_data;

   modport master (
      output cmd_valid, cmd_dev, cmd_command, cmd_address, cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dev, cmd_command, cmd_address, cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/ltc2600_chain_writer_fifo.sv
// First-word-fall-through command FIFO; the head entry is visible on
// pop_data whenever empty is low.
module sync_cmd_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_LV = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign full     = (level_q == DEPTH_LV);
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q;
      if (do_push && !do_pop)
         level_d = level_q + 1'b1;
      else if (!do_push && do_pop)
         level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/ltc2600_chain_writer.sv
// Queued SPI writer for a daisy chain of LTC2600-family DACs, with SCK
// divider, minimum csb-high spacing and a hardware CLR pulse.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting; clear request wins over a queued command (pop)
// ST_LOAD    | csb low, first frame bit on sdi, SCK held low
// ST_SHIFT   | SCK toggles every CLK_DIV cycles, sdi advances on falling SCK
// ST_CS_HOLD | csb high for CS_HIGH_CYC cycles before the next frame
// ST_CLEAR   | clrb low for CLR_CYC cycles
module ltc2600_chain_writer
   import ltc2600_chain_writer_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int N_DEV       = 1,
   parameter int FIFO_DEPTH  = 8,
   parameter int CLK_DIV     = 2,
   parameter int CS_HIGH_CYC = 4,
   parameter int CLR_CYC     = 8
) (
   input  logic                          clk,
   input  logic                          rstn,
   ltc2600_chain_writer_if.slave         cmd,
   input  logic                          clear_req,
   output logic                          sck,
   output logic                          sdi,
   output logic                          csb,
   output logic                          clrb,
   output logic                          busy,
   output logic                          write_complete,
   output logic                          cmd_error,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int FRAME_W = WORD_W * N_DEV;
   localparam int BIT_W   = $clog2(FRAME_W);
   localparam int TMR_W   = 16;

   localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(FRAME_W - 1);
   localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] CSH_LOAD = TMR_W'(CS_HIGH_CYC - 1);
   localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYC - 1);

   dac_cmd_t               push_entry, head;
   logic [$bits(dac_cmd_t)-1:0] fifo_rd;
   logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                   head_ok;
   logic [15:0]            data_ext;
   logic [FRAME_W-1:0]     frame;

   wr_state_t              state_q, state_d;
   logic [FRAME_W-1:0]     sr_q, sr_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [TMR_W-1:0]       div_cnt_q, div_cnt_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d;
   logic                   csb_q, csb_d;
   logic                   sck_q, sck_d;
   logic                   sdi_q, sdi_d;
   logic                   clrb_q, clrb_d;
   logic                   busy_q, busy_d;
   logic                   wc_q, wc_d;
   logic                   err_q, err_d;
   logic                   clr_pend_q, clr_pend_d;

   assign cmd.cmd_ready = ~fifo_full;
   assign fifo_push     = cmd.cmd_valid & ~fifo_full;

   always_comb begin
      data_ext           = 16'(cmd.cmd_data);
      push_entry.dev     = DEV_FIELD_W'(cmd.cmd_dev);
      push_entry.command = cmd.cmd_command;
      push_entry.address = cmd.cmd_address;
      push_entry.data    = data_ext << (16 - DATA_WIDTH);
   end

   sync_cmd_fifo #(
      .WIDTH (($bits(dac_cmd_t))),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign head    = dac_cmd_t'(fifo_rd);
   assign head_ok = (int'(head.dev) < N_DEV);

   // Far-end device occupies the MSBs so it is shifted out first.
   always_comb begin
      frame = '0;
      for (int d = 0; d < N_DEV; d++)
         frame[WORD_W*d +: WORD_W] = (int'(head.dev) == d) ? dac_word(head) : NOP_WORD;
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      bit_cnt_d  = bit_cnt_q;
      div_cnt_d  = div_cnt_q;
      tmr_d      = tmr_q;
      csb_d      = csb_q;
      sck_d      = sck_q;
      sdi_d      = sdi_q;
      clrb_d     = clrb_q;
      wc_d       = 1'b0;
      err_d      = 1'b0;
      fifo_pop   = 1'b0;
      clr_pend_d = clr_pend_q | clear_req;

      case (state_q)
         ST_IDLE: begin
            if (clr_pend_q) begin
               state_d    = ST_CLEAR;
               clr_pend_d = 1'b0;
               clrb_d     = 1'b0;
               tmr_d      = CLR_LOAD;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               if (head_ok) begin
                  state_d   = ST_LOAD;
                  sr_d      = frame;
                  sdi_d     = frame[FRAME_W-1];
                  csb_d     = 1'b0;
                  bit_cnt_d = BIT_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            state_d   = ST_SHIFT;
            div_cnt_d = DIV_LOAD;
         end
         ST_SHIFT: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - 1'b1;
            end else begin
               div_cnt_d = DIV_LOAD;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (bit_cnt_q == '0) begin
                     state_d = ST_CS_HOLD;
                     csb_d   = 1'b1;
                     sdi_d   = 1'b0;
                     wc_d    = 1'b1;
                     tmr_d   = CSH_LOAD;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 1'b1;
                     sr_d      = sr_q << 1;
                     sdi_d     = sr_q[FRAME_W-2];
                  end
               end
            end
         end
         ST_CS_HOLD: begin
            if (tmr_q == '0)
               state_d = ST_IDLE;
            else
               tmr_d = tmr_q - 1'b1;
         end
         ST_CLEAR: begin
            // Requests during the pulse fold into it.
            clr_pend_d = 1'b0;
            if (tmr_q == '0) begin
               state_d = ST_IDLE;
               clrb_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         div_cnt_q  <= '0;
         tmr_q      <= '0;
         csb_q      <= 1'b1;
         sck_q      <= 1'b0;
         sdi_q      <= 1'b0;
         clrb_q     <= 1'b1;
         busy_q     <= 1'b0;
         wc_q       <= 1'b0;
         err_q      <= 1'b0;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         div_cnt_q  <= div_cnt_d;
         tmr_q      <= tmr_d;
         csb_q      <= csb_d;
         sck_q      <= sck_d;
         sdi_q      <= sdi_d;
         clrb_q     <= clrb_d;
         busy_q     <= busy_d;
         wc_q       <= wc_d;
         err_q      <= err_d;
         clr_pend_q <= clr_pend_d;
      end
   end

   assign csb            = csb_q;
   assign sck            = sck_q;
   assign sdi            = sdi_q;
   assign clrb           = clrb_q;
   assign busy           = busy_q;
   assign write_complete = wc_q;
   assign cmd_error      = err_q;

endmodule

// File: tb/tb_ltc2600_chain_writer.sv
// Bench for the chain writer: a three-device, 12-bit chain driven with
// directed and random commands, frames captured off the SPI pins.
module tb_ltc2600_chain_writer;
   localparam int N_DEV       = 3;
   localparam int DATA_WIDTH  = 12;
   localparam int FIFO_DEPTH  = 4;
   localparam int CLK_DIV     = 2;
   localparam int CS_HIGH_CYC = 4;
   localparam int CLR_CYC     = 8;
   localparam int FB          = 32 * N_DEV;
   localparam int LOW_CYC     = 64 * N_DEV * CLK_DIV + 1;
   localparam logic [31:0] NOP_W = 32'h00F0_0000;

   logic       clk = 1'b0;
   logic       rstn;
   logic       clear_req;
   logic       sck, sdi, csb, clrb, busy, write_complete, cmd_error;
   logic [2:0] fifo_level;

   ltc2600_chain_writer_if #(.DEV_W(2), .DATA_WIDTH(DATA_WIDTH)) cmd_if ();

   ltc2600_chain_writer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .N_DEV       (N_DEV),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .CLK_DIV     (CLK_DIV),
      .CS_HIGH_CYC (CS_HIGH_CYC),
      .CLR_CYC     (CLR_CYC)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .cmd            (cmd_if),
      .clear_req      (clear_req),
      .sck            (sck),
      .sdi            (sdi),
      .csb            (csb),
      .clrb           (clrb),
      .busy           (busy),
      .write_complete (write_complete),
      .cmd_error      (cmd_error),
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: each device's 32-bit word, far-end device in the MSBs.
   function automatic logic [FB-1:0] exp_frame(input int dev, input logic [3:0] c,
                                                input logic [3:0] a, input logic [11:0] d);
      logic [FB-1:0] f;
      for (int k = 0; k < N_DEV; k++)
         f[32*k +: 32] = (k == dev) ? {8'h00, c, a, d, 4'h0} : NOP_W;
      return f;
   endfunction

   logic [FB-1:0] exp_q[$];
   int            exp_err = 0;

   // SPI pin monitor
   logic [FB-1:0] cap, last_cap;
   int  nbits = 0, low_cnt = 0, high_cnt = 0, frames_done = 0;
   int  wc_cnt = 0, err_cnt = 0, clr_pulses = 0, clr_len = 0, clr_len_last = 0;
   int  frames_at_clr = 0, max_level = 0, nonnop;
   bit  prev_csb = 1'b1, prev_sck = 1'b0, prev_clrb = 1'b1, had_frame = 1'b0;
   bit  csb_fell_in_clr = 1'b0, ready_low_seen = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         nbits = 0; low_cnt = 0; high_cnt = 0; had_frame = 1'b0; cap = '0;
         prev_csb = 1'b1; prev_sck = 1'b0; prev_clrb = 1'b1;
      end else begin
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (!cmd_if.cmd_ready) ready_low_seen = 1'b1;
         if (cmd_error) err_cnt++;
         if (write_complete) begin
            wc_cnt++;
            check_eq("wc_on_csb_rise", {csb, prev_csb}, 2'b10);
         end
         if (!csb) begin
            if (prev_csb) begin
               if (had_frame) check_eq("cs_gap", high_cnt >= CS_HIGH_CYC, 1'b1);
               if (!clrb) csb_fell_in_clr = 1'b1;
               low_cnt = 0;
               nbits = 0;
            end
            low_cnt++;
            if (sck && !prev_sck) begin
               cap = {cap[FB-2:0], sdi};
               nbits++;
            end
         end else begin
            if (!prev_csb) begin
               frames_done++;
               last_cap = cap;
               had_frame = 1'b1;
               high_cnt = 0;
               check_eq("frame_bits", nbits, FB);
               check_eq("csb_low_cyc", low_cnt, LOW_CYC);
               nonnop = 0;
               for (int k = 0; k < N_DEV; k++)
                  if (cap[32*k +: 32] != NOP_W) nonnop++;
               check_eq("one_dev_updated", nonnop, 1);
               check_eq("frame_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) check_eq("frame", cap, exp_q.pop_front());
            end
            high_cnt++;
         end
         if (!clrb) begin
            if (prev_clrb) begin
               clr_pulses++;
               clr_len = 0;
               frames_at_clr = frames_done;
            end
            clr_len++;
         end else if (!prev_clrb) begin
            clr_len_last = clr_len;
         end
         prev_csb = csb; prev_sck = sck; prev_clrb = clrb;
      end
   end

   task automatic push_cmd(input int dev, input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
      int t;
      t = 0;
      @(negedge clk);
      cmd_if.cmd_valid   = 1'b1;
      cmd_if.cmd_dev     = 2'(dev);
      cmd_if.cmd_command = c;
      cmd_if.cmd_address = a;
      cmd_if.cmd_data    = d;
      while (!cmd_if.cmd_ready && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check_eq("push_accept", cmd_if.cmd_ready, 1'b1);
      if (cmd_if.cmd_ready) begin
         @(posedge clk);
         if (dev < N_DEV) exp_q.push_back(exp_frame(dev, c, a, d));
         else exp_err++;
      end
      #1 cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy || fifo_level != 0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_eq("idle_in_time", t < budget, 1'b1);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, e0, w0, p0, t;
      rstn = 1'b0;
      clear_req = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_dev = '0;
      cmd_if.cmd_command = '0;
      cmd_if.cmd_address = '0;
      cmd_if.cmd_data = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_csb", csb, 1'b1);
      check_eq("rst_sck", sck, 1'b0);
      check_eq("rst_sdi", sdi, 1'b0);
      check_eq("rst_clrb", clrb, 1'b1);
      check_eq("rst_flags", {busy, write_complete, cmd_error}, 3'b000);
      check_eq("rst_level", fifo_level, 3'd0);
      check_eq("rst_ready", cmd_if.cmd_ready, 1'b1);
      rstn = 1'b1;

      // Single command to device 0, 12-bit code left-justified
      push_cmd(0, 4'h3, 4'h2, 12'hFFF);
      wait_idle(2000);
      check_eq("dev0_word", last_cap[31:0], 32'h0032_FFF0);
      check_eq("wc_count", wc_cnt, 1);

      // Middle device targeted: NOP, target, NOP on the wire
      push_cmd(1, 4'h0, 4'h5, 12'h123);
      wait_idle(2000);
      check_eq("dev1_frame", last_cap, {32'h00F0_0000, 32'h0005_1230, 32'h00F0_0000});

      // Out-of-range device is dropped with an error pulse
      f0 = frames_done;
      e0 = err_cnt;
      push_cmd(3, 4'h3, 4'h1, 12'h456);
      repeat (10) @(negedge clk);
      check_eq("bad_dev_err", err_cnt, e0 + 1);
      check_eq("bad_dev_noframe", frames_done, f0);
      check_eq("bad_dev_csb", csb, 1'b1);

      // Random commands, including out-of-range devices
      for (int i = 0; i < 10; i++)
         push_cmd($urandom_range(0, 3), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                  12'($urandom));
      wait_idle(20000);

      // Overfill the FIFO back-to-back
      max_level = 0;
      ready_low_seen = 1'b0;
      for (int i = 0; i < FIFO_DEPTH + 2; i++)
         push_cmd(i % N_DEV, 4'h3, 4'(i), 12'($urandom));
      wait_idle(20000);
      check_eq("fifo_max_level", max_level, FIFO_DEPTH);
      check_eq("ready_dropped", ready_low_seen, 1'b1);

      // Clear requested mid-frame, repeated while pending and during the pulse
      p0 = clr_pulses;
      push_cmd(0, 4'h3, 4'hA, 12'h111);
      push_cmd(2, 4'h3, 4'hB, 12'h222);
      t = 0;
      while (csb && t < 200) begin @(negedge clk); t++; end
      check_eq("clr_frame_started", csb, 1'b0);
      f0 = frames_done;
      pulse_clear();
      repeat (20) @(negedge clk);
      pulse_clear();
      t = 0;
      while (clrb && t < 2000) begin @(negedge clk); t++; end
      check_eq("clrb_asserted", clrb, 1'b0);
      pulse_clear();
      wait_idle(4000);
      repeat (20) @(negedge clk);
      check_eq("clr_single_pulse", clr_pulses, p0 + 1);
      check_eq("clr_len", clr_len_last, CLR_CYC);
      check_eq("clr_after_frame", frames_at_clr, f0 + 1);
      check_eq("no_frame_in_clr", csb_fell_in_clr, 1'b0);

      // Reset in the middle of a frame
      push_cmd(0, 4'h3, 4'h1, 12'hAAA);
      push_cmd(2, 4'h3, 4'h2, 12'h555);
      t = 0;
      while (!(nbits >= 10 && !csb) && t < 2000) begin @(negedge clk); t++; end
      check_eq("rst_mid_reached", nbits >= 10, 1'b1);
      w0 = wc_cnt;
      f0 = frames_done;
      #3 rstn = 1'b0;
      #1;
      check_eq("abort_pins", {csb, sck, sdi, clrb}, 4'b1001);
      check_eq("abort_level", fifo_level, 3'd0);
      check_eq("abort_busy", busy, 1'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_eq("abort_no_wc", wc_cnt, w0);
      rstn = 1'b1;
      push_cmd(2, 4'h4, 4'hF, 12'hC3C);
      wait_idle(2000);
      check_eq("post_rst_frames", frames_done, f0 + 1);
      check_eq("post_rst_frame", last_cap, {32'h004F_C3C0, 32'h00F0_0000, 32'h00F0_0000});

      check_eq("all_frames_sent", exp_q.size(), 0);
      check_eq("err_total", err_cnt, exp_err);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
